mul_seq_sm: RTL and testbench

- Parametrised sequential shift-add multiplier; next generation of the combinational carry-save array multiplier.
- Trades area for latency: one N-bit adder, one partial-product step per clock.
- Adds a start/done handshake and a per-operation signed (two's complement) / unsigned mode.
- Sits as a multi-cycle arithmetic unit behind a controller issuing one operation at a time.

---
 rtl/mul_seq_sm.sv | 102 ++++++++++
 tb/tb_mul_seq_sm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_sm.sv
// Sequential shift-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the product at the end.
module mul_seq_sm #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]  count;
    logic [N-1:0]   ma;
    logic [N-1:0]   mb;
    logic           neg;
    logic [2*N-1:0] acc;
    logic [N:0]     sum;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           accept;
    logic           last;

    assign accept = (state == IDLE) && start;
    assign last   = (count == CW'(N - 1));

    // -2^(N-1) negates to itself, which is the correct unsigned magnitude
    assign a_mag = (signed_mode && multiplicand[N-1])
                   ? (~multiplicand + N'(1)) : multiplicand;
    assign b_mag = (signed_mode && multiplier[N-1])
                   ? (~multiplier + N'(1)) : multiplier;

    assign sum = {1'b0, acc[2*N-1:N]} + {1'b0, (mb[0] ? ma : '0)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: if (last) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            ma      <= '0;
            mb      <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                ma    <= a_mag;
                mb    <= b_mag;
                neg   <= signed_mode & (multiplicand[N-1] ^ multiplier[N-1]);
                acc   <= '0;
                count <= '0;
            end
            if (state == CALC) begin
                acc   <= {sum, acc[N-1:1]};
                mb    <= mb >> 1;
                count <= count + CW'(1);
            end
            if (state == FIX) begin
                product <= neg ? (~acc + (2*N)'(1)) : acc;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_sm.sv
// Directed bench for mul_seq_sm: N=4 exhaustive, N=8 spot checks,
// handshake, reset mid-operation and operand changes after accept.
module tb_mul_seq_sm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s4, sm4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       busy4, done4;

    logic        s8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    int vecs = 0;
    int errs = 0;

    mul_seq_sm #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .signed_mode(sm4),
        .multiplicand(a4), .multiplier(b4),
        .product(p4), .busy(busy4), .done(done4)
    );

    mul_seq_sm #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .product(p8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lat counts cycles with the start-edge cycle as 1; ok covers
    // busy staying high until done and a single-cycle done pulse
    task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                       input logic toggle, output logic [7:0] res,
                       output int lat, output logic ok);
        @(negedge clk);
        s4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
        @(posedge clk);
        lat = 1; ok = 1'b1; res = '0;
        forever begin
            @(negedge clk);
            s4 = toggle ? ~s4 : 1'b0;
            if (toggle) begin
                a4 = ~a4; b4 = b4 + 4'd3; sm4 = ~sm4;
            end
            if (done4) break;
            if (!busy4) ok = 1'b0;
            lat++;
            if (lat > 40) begin
                ok = 1'b0;
                break;
            end
        end
        s4 = 1'b0;
        res = p4;
        @(negedge clk);
        if (done4 || busy4) ok = 1'b0;
    endtask

    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] res, output int lat,
                       output logic ok);
        @(negedge clk);
        s8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        @(posedge clk);
        lat = 1; ok = 1'b1; res = '0;
        forever begin
            @(negedge clk);
            s8 = 1'b0;
            if (done8) break;
            if (!busy8) ok = 1'b0;
            lat++;
            if (lat > 40) begin
                ok = 1'b0;
                break;
            end
        end
        res = p8;
        @(negedge clk);
        if (done8 || busy8) ok = 1'b0;
    endtask

    initial begin
        logic [7:0]  r4;
        logic [15:0] r8;
        logic [7:0]  e4;
        logic [7:0]  first;
        logic [3:0]  ra [0:20];
        logic [3:0]  rb [0:20];
        logic signed [3:0] sa, sb;
        int lat;
        int prod;
        logic ok;

        rst_n = 1'b0;
        s4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        s8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p4", 16'(p4), 16'h0);
        check("rst_busy4", 16'(busy4), 16'h0);
        check("rst_done4", 16'(done4), 16'h0);
        check("rst_p8", p8, 16'h0);
        check("rst_busy8", 16'(busy8), 16'h0);
        check("rst_done8", 16'(done8), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            op4(1'b0, i[7:4], i[3:0], 1'b0, r4, lat, ok);
            e4 = 8'(i[7:4] * i[3:0]);
            check("u4_prod", 16'(r4), 16'(e4));
            check("u4_lat", 16'(lat), 16'd6);
            check("u4_hs", 16'(ok), 16'h1);
        end

        op4(1'b1, 4'b1000, 4'b1000, 1'b0, r4, lat, ok);
        check("s4_8x8", 16'(r4), 16'h40);
        op4(1'b1, 4'hF, 4'h3, 1'b0, r4, lat, ok);
        check("s4_Fx3", 16'(r4), 16'hFD);
        op4(1'b1, 4'h7, 4'h8, 1'b0, r4, lat, ok);
        check("s4_7x8", 16'(r4), 16'hC8);

        for (int i = 0; i < 256; i++) begin
            op4(1'b1, i[7:4], i[3:0], 1'b0, r4, lat, ok);
            sa = i[7:4];
            sb = i[3:0];
            prod = int'(sa) * int'(sb);
            e4 = prod[7:0];
            check("s4_prod", 16'(r4), 16'(e4));
            check("s4_hs", 16'(ok), 16'h1);
        end

        op8(1'b0, 8'hFF, 8'hFF, r8, lat, ok);
        check("u8_FFxFF", r8, 16'hFE01);
        check("u8_lat", 16'(lat), 16'd10);
        check("u8_hs", 16'(ok), 16'h1);
        op8(1'b1, 8'h80, 8'h7F, r8, lat, ok);
        check("s8_80x7F", r8, 16'hC080);
        op8(1'b1, 8'h00, 8'h80, r8, lat, ok);
        check("s8_0x80", r8, 16'h0000);

        // start held high, fresh operands every cycle: accepts at edges 0,7,14
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            s4 = 1'b1; sm4 = 1'b0;
            ra[c] = 4'((c * 3 + 5) & 15);
            rb[c] = 4'((c * 7 + 2) & 15);
            a4 = ra[c]; b4 = rb[c];
            @(posedge clk);
            #1;
            check("hs_done", 16'(done4),
                  16'((c == 5) || (c == 12) || (c == 19)));
            if (c == 5 || c == 12 || c == 19) begin
                e4 = 8'(ra[c-5] * rb[c-5]);
                check("hs_prod", 16'(p4), 16'(e4));
            end
            if (c == 5) first = p4;
            if (c == 9) check("hs_hold", 16'(p4), 16'(first));
        end
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);

        // reset asserted in the second CALC cycle
        s4 = 1'b1; sm4 = 1'b0; a4 = 4'h9; b4 = 4'h7;
        @(posedge clk);
        @(negedge clk);
        s4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_p", 16'(p4), 16'h0);
        check("mid_rst_busy", 16'(busy4), 16'h0);
        check("mid_rst_done", 16'(done4), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op4(1'b0, 4'h9, 4'h7, 1'b0, r4, lat, ok);
        check("post_rst", 16'(r4), 16'h3F);
        check("post_rst_hs", 16'(ok), 16'h1);

        op4(1'b0, 4'hB, 4'h6, 1'b1, r4, lat, ok);
        check("tog_u", 16'(r4), 16'h42);
        check("tog_u_lat", 16'(lat), 16'd6);
        op4(1'b1, 4'hB, 4'h3, 1'b1, r4, lat, ok);
        check("tog_s", 16'(r4), 16'hF1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
